// File: rtl/minimig_autoconfig_ctrl.sv
// Autoconfig chain sequencer for the Minimig expansion boards (Z2 RAM,
// three Z3 RAM boards, Ethernet). Serves config-space reads from the
// nybble ROM, latches assigned base addresses, and patches the Z2 size
// nybble into the ROM on every (re)start.
module minimig_autoconfig_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic [4:0]  board_en,
    input  logic [1:0]  z2_size,
    input  logic        req,
    input  logic        wr,
    input  logic [5:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        ack,
    output logic [8:0]  rom_a_read,
    input  logic [3:0]  rom_q,
    output logic [8:0]  rom_a_write,
    output logic [3:0]  rom_d,
    output logic        rom_we,
    output logic [7:0]  base_z2,
    output logic [15:0] base_z3a,
    output logic [15:0] base_z3b,
    output logic [15:0] base_z3c,
    output logic [15:0] base_eth,
    output logic [4:0]  configured
);

    localparam int unsigned CUR_W    = 3;
    localparam int unsigned REG_W    = 6;
    localparam int unsigned ROM_AW   = 9;
    localparam int unsigned NYB_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned Z2BASE_W = 8;
    localparam int unsigned NBOARD   = 5;

    // FSM encoding
    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_SEEK = 3'd1;
    localparam logic [2:0] S_IDLE = 3'd2;
    localparam logic [2:0] S_RD_A = 3'd3;
    localparam logic [2:0] S_RD_W = 3'd4;
    localparam logic [2:0] S_RD_Q = 3'd5;
    localparam logic [2:0] S_ACK  = 3'd6;

    // Board indices; each selects a 64-nybble ROM region
    localparam logic [CUR_W-1:0] CUR_Z2   = 3'd0;
    localparam logic [CUR_W-1:0] CUR_Z3A  = 3'd1;
    localparam logic [CUR_W-1:0] CUR_Z3B  = 3'd2;
    localparam logic [CUR_W-1:0] CUR_Z3C  = 3'd3;
    localparam logic [CUR_W-1:0] CUR_ETH  = 3'd4;
    localparam logic [CUR_W-1:0] CUR_NULL = 3'd7;

    // Config-space register offsets (addr carries bits [6:1])
    localparam logic [REG_W-1:0] REG_Z2_BASE = 6'h24;
    localparam logic [REG_W-1:0] REG_Z3_BASE = 6'h22;
    localparam logic [REG_W-1:0] REG_SHUTUP  = 6'h26;

    localparam logic [ROM_AW-1:0] ROM_PATCH_ADDR = 9'h001;

    logic [2:0]          state_q, state_d;
    logic [CUR_W-1:0]    cur_q, cur_d;
    logic                adv_q, adv_d;
    logic                wr_acc_q, wr_acc_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [ROM_AW-1:0]   rom_a_read_q, rom_a_read_d;
    logic [NYB_W-1:0]    rom_d_q, rom_d_d;
    logic                rom_we_q, rom_we_d;
    logic [Z2BASE_W-1:0] base_z2_q, base_z2_d;
    logic [DATA_W-1:0]   base_z3a_q, base_z3a_d;
    logic [DATA_W-1:0]   base_z3b_q, base_z3b_d;
    logic [DATA_W-1:0]   base_z3c_q, base_z3c_d;
    logic [DATA_W-1:0]   base_eth_q, base_eth_d;
    logic [NBOARD-1:0]   configured_q, configured_d;

    // Chain order: Z2 -> Z3a -> Z3b -> Z3c -> ETH -> null
    function automatic logic [CUR_W-1:0] next_board(input logic [CUR_W-1:0] c);
        logic [CUR_W-1:0] n;
        case (c)
            CUR_Z2:  n = CUR_Z3A;
            CUR_Z3A: n = CUR_Z3B;
            CUR_Z3B: n = CUR_Z3C;
            CUR_Z3C: n = CUR_ETH;
            default: n = CUR_NULL;
        endcase
        return n;
    endfunction

    // A board takes part in the chain when enabled (Z2 also needs a size)
    function automatic logic board_eligible(input logic [CUR_W-1:0] c,
                                            input logic [NBOARD-1:0] en,
                                            input logic [1:0] sz);
        logic e;
        case (c)
            CUR_Z2:  e = en[0] && (sz != 2'd0);
            CUR_Z3A: e = en[1];
            CUR_Z3B: e = en[2];
            CUR_Z3C: e = en[3];
            CUR_ETH: e = en[4];
            default: e = 1'b0;
        endcase
        return e;
    endfunction

    // Z2 size nybble patched into the ROM; all-ones marks the board absent
    function automatic logic [NYB_W-1:0] z2_size_nybble(input logic [1:0] sz);
        logic [NYB_W-1:0] n;
        case (sz)
            2'd1:    n = 4'b0110;
            2'd2:    n = 4'b0111;
            2'd3:    n = 4'b0000;
            default: n = 4'b1111;
        endcase
        return n;
    endfunction

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        adv_d        = adv_q;
        wr_acc_d     = wr_acc_q;
        ack_d        = 1'b0;
        data_out_d   = data_out_q;
        rom_a_read_d = rom_a_read_q;
        rom_d_d      = rom_d_q;
        rom_we_d     = 1'b0;
        base_z2_d    = base_z2_q;
        base_z3a_d   = base_z3a_q;
        base_z3b_d   = base_z3b_q;
        base_z3c_d   = base_z3c_q;
        base_eth_d   = base_eth_q;
        configured_d = configured_q;

        case (state_q)
            S_INIT: begin
                rom_we_d = 1'b1;
                rom_d_d  = z2_size_nybble(z2_size);
                cur_d    = CUR_Z2;
                state_d  = S_SEEK;
            end

            S_SEEK: begin
                if (board_eligible(cur_q, board_en, z2_size) || (cur_q == CUR_NULL)) begin
                    state_d = S_IDLE;
                end else begin
                    cur_d = next_board(cur_q);
                end
            end

            S_IDLE: begin
                if (req) begin
                    adv_d = 1'b0;
                    if (wr) begin
                        wr_acc_d = 1'b1;
                        state_d  = S_ACK;
                        if (cur_q != CUR_NULL) begin
                            if ((cur_q == CUR_Z2) && (addr == REG_Z2_BASE)) begin
                                base_z2_d       = data_in[15:8];
                                configured_d[0] = 1'b1;
                                adv_d           = 1'b1;
                            end else if ((cur_q != CUR_Z2) && (addr == REG_Z3_BASE)) begin
                                adv_d = 1'b1;
                                case (cur_q)
                                    CUR_Z3A: begin
                                        base_z3a_d      = data_in;
                                        configured_d[1] = 1'b1;
                                    end
                                    CUR_Z3B: begin
                                        base_z3b_d      = data_in;
                                        configured_d[2] = 1'b1;
                                    end
                                    CUR_Z3C: begin
                                        base_z3c_d      = data_in;
                                        configured_d[3] = 1'b1;
                                    end
                                    CUR_ETH: begin
                                        base_eth_d      = data_in;
                                        configured_d[4] = 1'b1;
                                    end
                                    default: adv_d = 1'b0;
                                endcase
                            end else if (addr == REG_SHUTUP) begin
                                adv_d = 1'b1;
                            end
                        end
                        if (adv_d) begin
                            cur_d = next_board(cur_q);
                        end
                    end else begin
                        wr_acc_d     = 1'b0;
                        rom_a_read_d = {cur_q, addr};
                        state_d      = S_RD_A;
                    end
                end
            end

            S_RD_A: state_d = S_RD_W;

            S_RD_W: state_d = S_RD_Q;

            S_RD_Q: begin
                data_out_d = {rom_q, 12'hFFF};
                ack_d      = 1'b1;
                state_d    = S_ACK;
            end

            S_ACK: begin
                // Reads raised ack on entry; writes raise it on exit
                ack_d   = wr_acc_q;
                state_d = adv_q ? S_SEEK : S_IDLE;
            end

            default: state_d = S_INIT;
        endcase

        // Restart drops any in-flight access and wipes the configuration
        if (restart) begin
            state_d      = S_INIT;
            cur_d        = CUR_Z2;
            adv_d        = 1'b0;
            wr_acc_d     = 1'b0;
            ack_d        = 1'b0;
            rom_we_d     = 1'b0;
            base_z2_d    = '0;
            base_z3a_d   = '0;
            base_z3b_d   = '0;
            base_z3c_d   = '0;
            base_eth_d   = '0;
            configured_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            cur_q        <= CUR_Z2;
            adv_q        <= 1'b0;
            wr_acc_q     <= 1'b0;
            ack_q        <= 1'b0;
            data_out_q   <= 16'hFFFF;
            rom_a_read_q <= '0;
            rom_d_q      <= '0;
            rom_we_q     <= 1'b0;
            base_z2_q    <= '0;
            base_z3a_q   <= '0;
            base_z3b_q   <= '0;
            base_z3c_q   <= '0;
            base_eth_q   <= '0;
            configured_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            adv_q        <= adv_d;
            wr_acc_q     <= wr_acc_d;
            ack_q        <= ack_d;
            data_out_q   <= data_out_d;
            rom_a_read_q <= rom_a_read_d;
            rom_d_q      <= rom_d_d;
            rom_we_q     <= rom_we_d;
            base_z2_q    <= base_z2_d;
            base_z3a_q   <= base_z3a_d;
            base_z3b_q   <= base_z3b_d;
            base_z3c_q   <= base_z3c_d;
            base_eth_q   <= base_eth_d;
            configured_q <= configured_d;
        end
    end

    assign data_out    = data_out_q;
    assign ack         = ack_q;
    assign rom_a_read  = rom_a_read_q;
    assign rom_a_write = ROM_PATCH_ADDR;
    assign rom_d       = rom_d_q;
    assign rom_we      = rom_we_q;
    assign base_z2     = base_z2_q;
    assign base_z3a    = base_z3a_q;
    assign base_z3b    = base_z3b_q;
    assign base_z3c    = base_z3c_q;
    assign base_eth    = base_eth_q;
    assign configured  = configured_q;

endmodule
